multicycle_cu: RTL and testbench

- Moore FSM control unit for the multicycle RV32I datapath variant: one shared memory port for instructions and data, plus ALUOut, OldPC, IR and Data registers.
- Sequences each instruction over 3–5 states and drives every datapath mux and enable.
- Waits on a memory ready handshake and halts on illegal encodings.
- Sits beside the datapath; `instr` is the IR output, stable outside FETCH.

---
 rtl/cu_pkg.sv | 74 +++++++
 rtl/mc_alu_decode.sv | 56 +++++
 rtl/multicycle_cu.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_cu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package cu_pkg;

    localparam int unsigned OP_W   = 7;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned F7_W   = 7;
    localparam int unsigned ALU_W  = 3;
    localparam int unsigned IMM_W  = 3;
    localparam int unsigned SRC_W  = 2;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR_WB,
        S_HALT
    } state_t;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

    localparam logic [IMM_W-1:0] IMM_I = 3'b000;
    localparam logic [IMM_W-1:0] IMM_S = 3'b001;
    localparam logic [IMM_W-1:0] IMM_B = 3'b010;
    localparam logic [IMM_W-1:0] IMM_U = 3'b011;
    localparam logic [IMM_W-1:0] IMM_J = 3'b100;

    localparam logic [SRC_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SRC_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SRC_W-1:0] SRCA_RD1   = 2'b10;
    localparam logic [SRC_W-1:0] SRCA_ZERO  = 2'b11;

    localparam logic [SRC_W-1:0] SRCB_RD2  = 2'b00;
    localparam logic [SRC_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SRC_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SRC_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SRC_W-1:0] RES_DATA   = 2'b01;
    localparam logic [SRC_W-1:0] RES_ALURES = 2'b10;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

    // Immediate format selected purely by opcode; unknown opcodes fall back to I.
    function automatic logic [IMM_W-1:0] imm_src_of(input logic [OP_W-1:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_LUI:    return IMM_U;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// ALU operation decode and legality check for R, I-ALU and branch encodings.
module mc_alu_decode
    import cu_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    input  logic [F3_W-1:0]  func3,
    input  logic [F7_W-1:0]  func7,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic             illegal
);

    logic [ALU_W-1:0] f3_op;
    logic             f3_ok;

    // Shared func3 map for R and I-ALU: add, slt, or, and only.
    always_comb begin
        f3_op = ALU_ADD;
        f3_ok = 1'b1;
        case (func3)
            3'b000:  f3_op = ALU_ADD;
            3'b010:  f3_op = ALU_SLT;
            3'b110:  f3_op = ALU_OR;
            3'b111:  f3_op = ALU_AND;
            default: f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (op)
            OP_R: begin
                alu_ctrl = f3_op;
                if (!f3_ok) begin
                    illegal = 1'b1;
                end else if (func7 == 7'b0100000) begin
                    // Alternate func7 is only defined for sub.
                    if (func3 == 3'b000) alu_ctrl = ALU_SUB;
                    else                 illegal  = 1'b1;
                end else if (func7 != 7'b0000000) begin
                    illegal = 1'b1;
                end
            end
            OP_IMM: begin
                alu_ctrl = f3_op;
                illegal  = !f3_ok;
            end
            OP_BRANCH: begin
                alu_ctrl = ALU_SUB;
                illegal  = (func3[2:1] != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_cu.sv
// Moore control FSM for the shared-memory multicycle RV32I datapath.
module multicycle_cu
    import cu_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              Zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              MemWrite,
    output logic              AdrSrc,
    output logic              IRWrite,
    output logic              PCWrite,
    output logic [SRC_W-1:0]  ALUSrcA,
    output logic [SRC_W-1:0]  ALUSrcB,
    output logic [ALU_W-1:0]  ALUctrl,
    output logic [SRC_W-1:0]  ResultSrc,
    output logic [IMM_W-1:0]  ImmSrc,
    output logic              RegWrite,
    output logic              halted
);

    state_t state;
    state_t state_n;

    logic [OP_W-1:0]  op;
    logic [F3_W-1:0]  func3;
    logic [F7_W-1:0]  func7;
    logic [ALU_W-1:0] dec_alu;
    logic             dec_illegal;
    logic             unused_instr;

    assign op           = instr[6:0];
    assign func3        = instr[14:12];
    assign func7        = instr[31:25];
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    mc_alu_decode u_alu_decode (
        .op       (op),
        .func3    (func3),
        .func7    (func7),
        .alu_ctrl (dec_alu),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_n;
    end

    // Opcode dispatch out of DECODE; illegal encodings halt or retire as NOP.
    function automatic state_t dispatch(input logic [OP_W-1:0] o, input logic bad);
        state_t ill;
        ill = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        case (o)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_R:              return bad ? ill : S_EXECR;
            OP_IMM:            return bad ? ill : S_EXECI;
            OP_BRANCH:         return bad ? ill : S_BRANCH;
            OP_JAL:            return S_JAL;
            OP_JALR:           return S_JALR;
            OP_LUI:            return S_LUI;
            default:           return ill;
        endcase
    endfunction

    always_comb begin
        state_n   = state;
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        ALUctrl   = ALU_ADD;
        ResultSrc = RES_ALUOUT;
        ImmSrc    = imm_src_of(op);
        RegWrite  = 1'b0;
        halted    = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_n = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                state_n = dispatch(op, dec_illegal);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_n = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_n = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_n   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) state_n = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                ALUctrl = dec_alu;
                state_n = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUctrl = dec_alu;
                state_n = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
                state_n = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                state_n   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_RD2;
                ALUctrl   = ALU_SUB;
                ResultSrc = RES_ALUOUT;
                PCWrite   = func3[0] ? !Zero : Zero;
                state_n   = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
                state_n   = S_ALUWB;
            end
            S_JALR: begin
                // PC takes rs1+imm before rd is overwritten, so rd==rs1 is safe.
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURES;
                PCWrite   = 1'b1;
                state_n   = S_JALR_WB;
            end
            S_JALR_WB: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                RegWrite  = 1'b1;
                state_n   = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_n = S_HALT;
            end
            default: state_n = S_FETCH;
        endcase

        // Reset suppresses every side effect, including an in-flight store.
        if (rst) begin
            mem_req  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            halted   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_cu.sv
// Directed cycle-by-cycle check of the multicycle control unit outputs.
module tb_multicycle_cu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Zero;
    logic        mem_ready;

    logic        mem_req0, MemWrite0, AdrSrc0, IRWrite0, PCWrite0, RegWrite0, halted0;
    logic [1:0]  ALUSrcA0, ALUSrcB0, ResultSrc0;
    logic [2:0]  ALUctrl0, ImmSrc0;
    logic        mem_req1, MemWrite1, AdrSrc1, IRWrite1, PCWrite1, RegWrite1, halted1;
    logic [1:0]  ALUSrcA1, ALUSrcB1, ResultSrc1;
    logic [2:0]  ALUctrl1, ImmSrc1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_cu #(.HALT_ON_ILLEGAL(1'b1)) u_dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req0), .MemWrite(MemWrite0), .AdrSrc(AdrSrc0), .IRWrite(IRWrite0),
        .PCWrite(PCWrite0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0), .ALUctrl(ALUctrl0),
        .ResultSrc(ResultSrc0), .ImmSrc(ImmSrc0), .RegWrite(RegWrite0), .halted(halted0)
    );

    multicycle_cu #(.HALT_ON_ILLEGAL(1'b0)) u_dut_nop (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req1), .MemWrite(MemWrite1), .AdrSrc(AdrSrc1), .IRWrite(IRWrite1),
        .PCWrite(PCWrite1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1), .ALUctrl(ALUctrl1),
        .ResultSrc(ResultSrc1), .ImmSrc(ImmSrc1), .RegWrite(RegWrite1), .halted(halted1)
    );

    logic [31:0] o0, o1;
    assign o0 = 32'({mem_req0, MemWrite0, AdrSrc0, IRWrite0, PCWrite0, ALUSrcA0, ALUSrcB0,
                     ALUctrl0, ResultSrc0, ImmSrc0, RegWrite0, halted0});
    assign o1 = 32'({mem_req1, MemWrite1, AdrSrc1, IRWrite1, PCWrite1, ALUSrcA1, ALUSrcB1,
                     ALUctrl1, ResultSrc1, ImmSrc1, RegWrite1, halted1});

    // Packs one expected output set in the same order as o0/o1.
    function automatic logic [31:0] sig(input logic mreq, input logic mw, input logic adr,
                                        input logic irw, input logic pcw,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [2:0] alu, input logic [1:0] rs,
                                        input logic [2:0] imm, input logic rw, input logic h);
        return 32'({mreq, mw, adr, irw, pcw, sa, sb, alu, rs, imm, rw, h});
    endfunction

    function automatic logic [31:0] f_exp(input logic [2:0] imm);
        return sig(1, 0, 0, 1, 1, 2'b00, 2'b10, 3'b000, 2'b10, imm, 0, 0);
    endfunction

    function automatic logic [31:0] d_exp(input logic [2:0] imm);
        return sig(0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 2'b00, imm, 0, 0);
    endfunction

    function automatic logic [31:0] wb_exp(input logic [2:0] imm);
        return sig(0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, imm, 1, 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
        end
    endtask

    // Drive handshake inputs, compare one cycle of outputs, advance past the edge.
    task automatic cyc(input string tag, input logic rdy, input logic z, input logic [31:0] exp);
        mem_ready = rdy;
        Zero      = z;
        #1;
        check(tag, o0, exp);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] r_ins [4]  = '{32'h4000_0033, 32'h0000_7033, 32'h0000_2033, 32'h0000_6033};
    logic [2:0]  r_alu [4]  = '{3'b001, 3'b010, 3'b101, 3'b011};
    logic [31:0] b_ins [4]  = '{32'h0000_0463, 32'h0000_0463, 32'h0000_1463, 32'h0000_1463};
    logic        b_z   [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        b_pcw [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] il_ins [4] = '{32'hFFFF_FFFF, 32'h4000_2033, 32'h0000_1033, 32'h0000_2063};
    logic [2:0]  il_imm [4] = '{3'b000, 3'b000, 3'b000, 3'b010};

    initial begin
        rst = 1'b1; instr = 32'h0; Zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc("reset", 1, 0, sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000, 0, 0));
        rst = 1'b0;

        // addi x1,x0,5
        instr = 32'h0050_0093;
        cyc("addi_fetch", 1, 0, f_exp(3'b000));
        cyc("addi_decode", 1, 0, d_exp(3'b000));
        cyc("addi_execi", 1, 0, sig(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000, 0, 0));
        cyc("addi_aluwb", 1, 0, wb_exp(3'b000));

        // lw x5,8(x0) with two wait states
        instr = 32'h0080_2283;
        cyc("lw_fetch", 1, 0, f_exp(3'b000));
        cyc("lw_decode", 1, 0, d_exp(3'b000));
        cyc("lw_memadr", 1, 0, sig(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000, 0, 0));
        cyc("lw_wait0", 0, 0, sig(1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 0));
        cyc("lw_wait1", 0, 0, sig(1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 0));
        cyc("lw_ready", 1, 0, sig(1, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 0));
        cyc("lw_memwb", 1, 0, sig(0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000, 1, 0));

        // R-type ops
        for (int i = 0; i < 4; i++) begin
            instr = r_ins[i];
            cyc($sformatf("r%0d_fetch", i), 1, 0, f_exp(3'b000));
            cyc($sformatf("r%0d_decode", i), 1, 0, d_exp(3'b000));
            cyc($sformatf("r%0d_execr", i), 1, 0,
                sig(0, 0, 0, 0, 0, 2'b10, 2'b00, r_alu[i], 2'b00, 3'b000, 0, 0));
            cyc($sformatf("r%0d_aluwb", i), 1, 0, wb_exp(3'b000));
        end

        // beq/bne with both Zero polarities
        for (int i = 0; i < 4; i++) begin
            instr = b_ins[i];
            cyc($sformatf("br%0d_fetch", i), 1, 0, f_exp(3'b010));
            cyc($sformatf("br%0d_decode", i), 1, 0, d_exp(3'b010));
            cyc($sformatf("br%0d_branch", i), 1, b_z[i],
                sig(0, 0, 0, 0, b_pcw[i], 2'b10, 2'b00, 3'b001, 2'b00, 3'b010, 0, 0));
        end

        // jal x1,8
        instr = 32'h0080_00EF;
        cyc("jal_fetch", 1, 0, f_exp(3'b100));
        cyc("jal_decode", 1, 0, d_exp(3'b100));
        cyc("jal_jal", 1, 0, sig(0, 0, 0, 0, 1, 2'b01, 2'b10, 3'b000, 2'b00, 3'b100, 0, 0));
        cyc("jal_aluwb", 1, 0, wb_exp(3'b100));

        // lui x1,0x12345
        instr = 32'h1234_50B7;
        cyc("lui_fetch", 1, 0, f_exp(3'b011));
        cyc("lui_decode", 1, 0, d_exp(3'b011));
        cyc("lui_lui", 1, 0, sig(0, 0, 0, 0, 0, 2'b11, 2'b01, 3'b000, 2'b00, 3'b011, 0, 0));
        cyc("lui_aluwb", 1, 0, wb_exp(3'b011));

        // jalr x1,0(x1)
        instr = 32'h0000_80E7;
        cyc("jalr_fetch", 1, 0, f_exp(3'b000));
        cyc("jalr_decode", 1, 0, d_exp(3'b000));
        cyc("jalr_jalr", 1, 0, sig(0, 0, 0, 0, 1, 2'b10, 2'b01, 3'b000, 2'b10, 3'b000, 0, 0));
        cyc("jalr_wb", 1, 0, sig(0, 0, 0, 0, 0, 2'b01, 2'b10, 3'b000, 2'b10, 3'b000, 1, 0));

        // sw x5,8(x0) interrupted by reset while stalled in MEMWRITE
        instr = 32'h0050_2423;
        cyc("sw_fetch", 1, 0, f_exp(3'b001));
        cyc("sw_decode", 1, 0, d_exp(3'b001));
        cyc("sw_memadr", 1, 0, sig(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b001, 0, 0));
        cyc("sw_stall", 0, 0, sig(1, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001, 0, 0));
        rst = 1'b1;
        cyc("sw_rst0", 1, 0, sig(0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001, 0, 0));
        cyc("sw_rst1", 1, 0, sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 2'b10, 3'b001, 0, 0));
        cyc("sw_rst2", 1, 0, sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 2'b10, 3'b001, 0, 0));
        rst = 1'b0;
        cyc("sw_refetch", 1, 0, f_exp(3'b001));
        cyc("sw_decode2", 1, 0, d_exp(3'b001));
        cyc("sw_memadr2", 1, 0, sig(0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 3'b001, 0, 0));
        cyc("sw_write", 1, 0, sig(1, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001, 0, 0));
        cyc("sw_next", 1, 0, f_exp(3'b001));

        // Illegal encodings: halt on the default instance, NOP on the other
        for (int i = 0; i < 4; i++) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            instr = il_ins[i];
            cyc($sformatf("il%0d_fetch", i), 1, 0, f_exp(il_imm[i]));
            cyc($sformatf("il%0d_decode", i), 1, 0, d_exp(il_imm[i]));
            check($sformatf("il%0d_nop_fetch", i), o1, f_exp(il_imm[i]));
            cyc($sformatf("il%0d_halt", i), 1, 0,
                sig(0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, il_imm[i], 0, 1));
            if (i == 0) begin
                for (int k = 0; k < 20; k++)
                    cyc($sformatf("il_hold%0d", k), k[0], k[1],
                        sig(0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 0, 1));
            end
        end

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc("halt_exit", 1, 0, f_exp(3'b010));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
